pic_control_logic: RTL and testbench
====================================

# pic_control_logic

Interrupt sequencing controller for the 8259-style PIC. Sits between the IRQ capture block (edge/level detection into the request register) and the CPU bus interface. It resolves priority among unmasked pending requests against the in-service register, raises INT, runs the two-pulse INTA acknowledge sequence, drives the vector byte, and applies EOI commands, including rotating priority and auto-EOI.

## Interface
Parameters:
- NUM_IRQ, 8, number of request lines; fixed at 8 for 8259 compatibility, other values unsupported.
- LEVEL_W, 3, width of a level index, clog2(NUM_IRQ).

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- irr  in  8  pending requests from the IRQ capture block.
- imr  in  8  mask; 1 means masked.
- vector_base  in  5  ICW2 T7..T3.
- aeoi  in  1  auto-EOI mode enable.
- inta_n  in  1  CPU acknowledge, active-low, already synchronous to clk.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = clear isr[eoi_level]; 0 = non-specific.
- eoi_rotate  in  1  rotate priority on this EOI.
- eoi_level  in  3  level for specific EOI.
- int_out  out  1  interrupt request to CPU.
- irr_clear  out  8  one-hot one-cycle pulse clearing the acknowledged irr bit.
- isr  out  8  in-service register.
- data_out  out  8  vector byte.
- data_oe  out  1  data_out valid and bus drive enable.

## Operation
- Priority base: lowest_prio register, reset 7, so IRQ0 is highest. Priority order is lowest_prio+1, lowest_prio+2, … (mod 8).
- A request is eligible when irr & ~imr is nonzero and its highest-priority bit outranks the highest-priority isr bit (fully nested mode). An empty isr ranks below everything.
- FSM states and transitions:
  - IDLE: go to REQ when a request is eligible.
  - REQ: int_out=1. On the first inta_n falling edge, go to ACK1.
  - ACK1: re-resolve priority on that fall edge.
    - Valid winner L: set isr[L], pulse irr_clear[L], latch L.
    - No eligible request (spurious): latch L=7, leave isr and irr_clear unchanged.
    - On the inta_n rising edge, go to WAIT2.
  - WAIT2: on the second inta_n falling edge, go to ACK2.
  - ACK2: data_out={vector_base, L}, data_oe=1 while inta_n is low. On the rising edge:
    - data_oe=0.
    - If aeoi and not spurious, clear isr[L].
    - Go to IDLE.
- int_out drops on the first INTA fall. If the request vanishes while in REQ before INTA, int_out stays high and the cycle ends as spurious.
- EOI handling (on eoi_valid, any state):
  - Non-specific: clear the highest-priority isr bit; no-op if isr is 0.
  - Specific: clear isr[eoi_level].
  - eoi_rotate=1: set lowest_prio to the cleared level. A non-specific rotate with isr=0 leaves lowest_prio unchanged.
- Simultaneous events:
  - ISR set (ACK1) and EOI clear in the same cycle both apply. If both target the same bit, the set wins.
  - AEOI clear and an EOI in the same cycle: both clears apply.

## Timing
- Reset values: int_out=0, irr_clear=0, isr=0, data_out=0, data_oe=0, lowest_prio=7, FSM=IDLE, inta_prev=1.
- Edge detection uses a registered inta_prev. Fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
- irr eligible at edge N: int_out is high after edge N+1 (state registered).
- First INTA fall seen at edge N: isr, irr_clear and int_out=0 all update at edge N+1. irr_clear lasts exactly one cycle.
- Second INTA fall seen at edge N: data_oe=1 and data_out valid from edge N+1. data_oe=0 from the edge after the rise is seen.
- EOI effects are visible one cycle after the eoi_valid edge.
- Reset mid-sequence (any state) returns everything to reset values immediately. A half-completed INTA sequence is abandoned.

## Structure
- Shared package pic_pkg holds:
  - FSM state enum: IDLE, REQ, ACK1, WAIT2, ACK2.
  - NUM_IRQ and LEVEL_W constants.
  - EOI command encoding.
- Sub-module pic_priority_resolver: combinational rotate-by-lowest_prio, find-first and un-rotate. Outputs a valid flag and a level index. Instantiated twice, once for irr & ~imr and once for isr.

## Test plan
- Basic ack: imr=0, vector_base=5'h08, irr=8'h04, two INTA pulses.
  - int_out rises, irr_clear=8'h04 for one cycle, isr=8'h04.
  - data_out=8'h42 with data_oe=1 during the second pulse.
- Nesting: isr=8'h04, irr=8'h20 -> no int_out. Then irr=8'h01 -> int_out=1, and the ack sets isr=8'h05.
- Spurious: irr=8'h02 raises int_out, irr drops to 0 before the first INTA -> isr unchanged, data_out={vector_base,3'd7}.
- EOI with rotate: isr=8'h08, non-specific EOI with eoi_rotate=1.
  - isr=0 and lowest_prio=3.
  - irr=8'h11 then acks level 4 first.
- AEOI: aeoi=1, irr=8'h80, full INTA sequence -> isr=8'h80 after the first pulse, 8'h00 after the second rise.
- Reset mid-sequence: assert rst in WAIT2 -> all outputs 0, lowest_prio=7. The next request completes normally.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the 8259-style PIC control logic
// Contents: FSM state enum, request-line constants, EOI command encoding, level-to-mask helper.
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int LEVEL_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4
    } pic_state_e;

    // Encoded as {rotate, specific}
    typedef enum logic [1:0] {
        EOI_NONSPEC      = 2'b00,
        EOI_SPECIFIC     = 2'b01,
        EOI_ROT_NONSPEC  = 2'b10,
        EOI_ROT_SPECIFIC = 2'b11
    } eoi_cmd_e;

    function automatic logic [NUM_IRQ-1:0] level_to_mask(input logic [LEVEL_W-1:0] lvl);
        logic [NUM_IRQ-1:0] m;
        m      = '0;
        m[lvl] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - rotating-priority find-first over an 8-bit request vector
// Ports:
//   req          in  8  candidate bits
//   lowest_prio  in  3  level with the lowest priority; lowest_prio+1 is highest
//   valid        out 1  any bit of req set
//   level        out 3  absolute level of the highest-priority set bit
//   rank         out 3  priority position of that bit, 0 = highest
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    input  logic [LEVEL_W-1:0] lowest_prio,
    output logic               valid,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] rank
);

    logic [NUM_IRQ-1:0] rotated;

    // rotated[0] holds the highest-priority level, rotated[7] the lowest
    always_comb begin
        logic [LEVEL_W-1:0] idx;
        rotated = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx        = lowest_prio + LEVEL_W'(i) + LEVEL_W'(1);
            rotated[i] = req[idx];
        end
    end

    // Scan downwards so the lowest set position is the one that sticks
    always_comb begin
        valid = 1'b0;
        rank  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                valid = 1'b1;
                rank  = LEVEL_W'(i);
            end
        end
        level = lowest_prio + rank + LEVEL_W'(1);
    end

endmodule

// File: rtl/pic_control_logic.sv
// rtl/pic_control_logic.sv - 8259-style interrupt sequencing: priority, INT, INTA cycle, vector, EOI
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   irr, imr                       pending requests, mask (1 = masked)
//   vector_base                    ICW2 T7..T3
//   aeoi                           auto-EOI enable
//   inta_n                         CPU acknowledge, active-low, clk-synchronous
//   eoi_valid/specific/rotate/level EOI command strobe and fields
//   int_out                        interrupt request to CPU
//   irr_clear                      one-cycle one-hot clear of the acknowledged request
//   isr                            in-service register
//   data_out, data_oe              vector byte and its bus drive enable
module pic_control_logic #(
    parameter int NUM_IRQ = 8,
    parameter int LEVEL_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [4:0]         vector_base,
    input  logic               aeoi,
    input  logic               inta_n,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic               eoi_rotate,
    input  logic [LEVEL_W-1:0] eoi_level,
    output logic               int_out,
    output logic [NUM_IRQ-1:0] irr_clear,
    output logic [NUM_IRQ-1:0] isr,
    output logic [7:0]         data_out,
    output logic               data_oe
);
    import pic_pkg::*;

    pic_state_e         state, state_next;
    logic               inta_prev;
    logic [LEVEL_W-1:0] lowest_prio, lowest_prio_next;
    logic [LEVEL_W-1:0] ack_level, ack_level_next;
    logic               spurious, spurious_next;

    logic               int_out_next;
    logic [NUM_IRQ-1:0] irr_clear_next;
    logic [7:0]         data_out_next;
    logic               data_oe_next;
    logic [NUM_IRQ-1:0] isr_set, aeoi_clr, eoi_clr, isr_next;

    logic               inta_fall, inta_rise;
    logic               req_valid, isr_valid, eligible;
    logic [LEVEL_W-1:0] req_level, req_rank, isr_level, isr_rank;
    logic [NUM_IRQ-1:0] req_masked;
    eoi_cmd_e           eoi_cmd;

    assign inta_fall  = inta_prev & ~inta_n;
    assign inta_rise  = ~inta_prev & inta_n;
    assign req_masked = irr & ~imr;
    assign eoi_cmd    = eoi_cmd_e'({eoi_rotate, eoi_specific});

    pic_priority_resolver u_req_res (
        .req         (req_masked),
        .lowest_prio (lowest_prio),
        .valid       (req_valid),
        .level       (req_level),
        .rank        (req_rank)
    );

    pic_priority_resolver u_isr_res (
        .req         (isr),
        .lowest_prio (lowest_prio),
        .valid       (isr_valid),
        .level       (isr_level),
        .rank        (isr_rank)
    );

    // Fully nested: a request must strictly outrank everything in service
    assign eligible = req_valid && (!isr_valid || (req_rank < isr_rank));

    always_comb begin
        state_next     = state;
        irr_clear_next = '0;
        data_out_next  = data_out;
        data_oe_next   = data_oe;
        ack_level_next = ack_level;
        spurious_next  = spurious;
        isr_set        = '0;
        aeoi_clr       = '0;
        case (state)
            IDLE: begin
                if (eligible) state_next = REQ;
            end
            REQ: begin
                // Priority is re-resolved here; the request seen in IDLE may be gone
                if (inta_fall) begin
                    state_next = ACK1;
                    if (eligible) begin
                        isr_set        = level_to_mask(req_level);
                        irr_clear_next = level_to_mask(req_level);
                        ack_level_next = req_level;
                        spurious_next  = 1'b0;
                    end else begin
                        ack_level_next = LEVEL_W'(7);
                        spurious_next  = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) state_next = WAIT2;
            end
            WAIT2: begin
                if (inta_fall) begin
                    state_next    = ACK2;
                    data_out_next = {vector_base, ack_level};
                    data_oe_next  = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_next    = IDLE;
                    data_oe_next  = 1'b0;
                    data_out_next = '0;
                    if (aeoi && !spurious) aeoi_clr = level_to_mask(ack_level);
                end
            end
            default: state_next = IDLE;
        endcase
        int_out_next = (state_next == REQ);
    end

    always_comb begin
        eoi_clr          = '0;
        lowest_prio_next = lowest_prio;
        if (eoi_valid) begin
            case (eoi_cmd)
                EOI_NONSPEC: begin
                    if (isr_valid) eoi_clr = level_to_mask(isr_level);
                end
                EOI_SPECIFIC: begin
                    eoi_clr = level_to_mask(eoi_level);
                end
                EOI_ROT_NONSPEC: begin
                    if (isr_valid) begin
                        eoi_clr          = level_to_mask(isr_level);
                        lowest_prio_next = isr_level;
                    end
                end
                EOI_ROT_SPECIFIC: begin
                    eoi_clr          = level_to_mask(eoi_level);
                    lowest_prio_next = eoi_level;
                end
                default: ;
            endcase
        end
    end

    // The set is ORed in last so an acknowledge beats an EOI on the same bit
    assign isr_next = (isr & ~(eoi_clr | aeoi_clr)) | isr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            inta_prev   <= 1'b1;
            lowest_prio <= LEVEL_W'(7);
            ack_level   <= '0;
            spurious    <= 1'b0;
            int_out     <= 1'b0;
            irr_clear   <= '0;
            isr         <= '0;
            data_out    <= '0;
            data_oe     <= 1'b0;
        end else begin
            state       <= state_next;
            inta_prev   <= inta_n;
            lowest_prio <= lowest_prio_next;
            ack_level   <= ack_level_next;
            spurious    <= spurious_next;
            int_out     <= int_out_next;
            irr_clear   <= irr_clear_next;
            isr         <= isr_next;
            data_out    <= data_out_next;
            data_oe     <= data_oe_next;
        end
    end

endmodule

// File: tb/tb_pic_control_logic.sv
// tb/tb_pic_control_logic.sv - directed self-checking bench for pic_control_logic
module tb_pic_control_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irr, imr;
    logic [4:0] vector_base;
    logic       aeoi, inta_n;
    logic       eoi_valid, eoi_specific, eoi_rotate;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] irr_clear, isr, data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] clr_seen, isr_seen, dout_seen;
    logic       doe_seen;

    always #5 clk = ~clk;

    pic_control_logic dut (
        .clk          (clk),
        .rst          (rst),
        .irr          (irr),
        .imr          (imr),
        .vector_base  (vector_base),
        .aeoi         (aeoi),
        .inta_n       (inta_n),
        .eoi_valid    (eoi_valid),
        .eoi_specific (eoi_specific),
        .eoi_rotate   (eoi_rotate),
        .eoi_level    (eoi_level),
        .int_out      (int_out),
        .irr_clear    (irr_clear),
        .isr          (isr),
        .data_out     (data_out),
        .data_oe      (data_oe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Two INTA pulses; the bench plays the capture block and drops the acknowledged irr bit
    task automatic inta_cycle(output logic [7:0] clr, output logic [7:0] isr1,
                              output logic [7:0] dout, output logic doe);
        inta_n = 1'b0;
        tick();
        clr  = irr_clear;
        isr1 = isr;
        irr  = irr & ~irr_clear;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        dout = data_out;
        doe  = data_oe;
        inta_n = 1'b1;
        tick();
    endtask

    task automatic eoi(input logic specific, input logic rotate, input logic [2:0] level);
        eoi_valid    = 1'b1;
        eoi_specific = specific;
        eoi_rotate   = rotate;
        eoi_level    = level;
        tick();
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
        eoi_level    = 3'd0;
    endtask

    initial begin
        rst = 1'b1; irr = 8'h00; imr = 8'h00; vector_base = 5'h08; aeoi = 1'b0;
        inta_n = 1'b1; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
        tick();
        tick();
        check("reset_int_out", {7'd0, int_out}, 8'h00);
        check("reset_isr", isr, 8'h00);
        check("reset_irr_clear", irr_clear, 8'h00);
        check("reset_data_oe", {7'd0, data_oe}, 8'h00);
        check("reset_data_out", data_out, 8'h00);
        check("reset_lowest_prio", {5'd0, dut.lowest_prio}, 8'h07);
        rst = 1'b0;
        tick();

        // Basic acknowledge of IRQ2
        irr = 8'h04;
        tick();
        check("basic_int_out", {7'd0, int_out}, 8'h01);
        inta_n = 1'b0;
        tick();
        check("basic_irr_clear", irr_clear, 8'h04);
        check("basic_isr", isr, 8'h04);
        check("basic_int_drop", {7'd0, int_out}, 8'h00);
        irr = 8'h00;
        tick();
        check("basic_irr_clear_1cyc", irr_clear, 8'h00);
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check("basic_data_out", data_out, 8'h42);
        check("basic_data_oe", {7'd0, data_oe}, 8'h01);
        tick();
        check("basic_data_oe_hold", {7'd0, data_oe}, 8'h01);
        inta_n = 1'b1;
        tick();
        check("basic_data_oe_off", {7'd0, data_oe}, 8'h00);
        check("basic_isr_kept", isr, 8'h04);

        // Nesting: IRQ5 below in-service IRQ2, then IRQ0 above it
        irr = 8'h20;
        tick();
        tick();
        check("nest_low_no_int", {7'd0, int_out}, 8'h00);
        irr = 8'h21;
        tick();
        check("nest_high_int", {7'd0, int_out}, 8'h01);
        inta_cycle(clr_seen, isr_seen, dout_seen, doe_seen);
        check("nest_irr_clear", clr_seen, 8'h01);
        check("nest_isr", isr_seen, 8'h05);
        check("nest_data_out", dout_seen, 8'h40);
        irr = 8'h00;
        eoi(1'b0, 1'b0, 3'd0);
        check("eoi_nonspec", isr, 8'h04);
        eoi(1'b1, 1'b0, 3'd2);
        check("eoi_specific", isr, 8'h00);

        // Spurious: request disappears before INTA
        irr = 8'h02;
        tick();
        check("spur_int_out", {7'd0, int_out}, 8'h01);
        irr = 8'h00;
        tick();
        check("spur_int_held", {7'd0, int_out}, 8'h01);
        inta_cycle(clr_seen, isr_seen, dout_seen, doe_seen);
        check("spur_irr_clear", clr_seen, 8'h00);
        check("spur_isr", isr_seen, 8'h00);
        check("spur_data_out", dout_seen, 8'h47);
        check("spur_data_oe", {7'd0, doe_seen}, 8'h01);

        // Rotating non-specific EOI
        irr = 8'h08;
        tick();
        inta_cycle(clr_seen, isr_seen, dout_seen, doe_seen);
        check("rot_setup_isr", isr, 8'h08);
        eoi(1'b0, 1'b1, 3'd0);
        check("rot_isr", isr, 8'h00);
        check("rot_lowest_prio", {5'd0, dut.lowest_prio}, 8'h03);
        irr = 8'h11;
        tick();
        check("rot_int_out", {7'd0, int_out}, 8'h01);
        inta_cycle(clr_seen, isr_seen, dout_seen, doe_seen);
        check("rot_ack_level4", clr_seen, 8'h10);
        check("rot_data_out", dout_seen, 8'h44);
        tick();
        check("rot_irq0_blocked", {7'd0, int_out}, 8'h00);
        eoi(1'b1, 1'b0, 3'd4);
        tick();
        inta_cycle(clr_seen, isr_seen, dout_seen, doe_seen);
        check("rot_ack_level0", clr_seen, 8'h01);
        eoi(1'b1, 1'b1, 3'd7);
        check("rot_specific_prio", {5'd0, dut.lowest_prio}, 8'h07);
        check("rot_specific_isr", isr, 8'h01);
        eoi(1'b0, 1'b0, 3'd0);
        check("eoi_clear_last", isr, 8'h00);
        eoi(1'b0, 1'b1, 3'd0);
        check("rot_empty_isr_prio", {5'd0, dut.lowest_prio}, 8'h07);

        // Auto-EOI
        aeoi = 1'b1;
        irr = 8'h80;
        tick();
        check("aeoi_int_out", {7'd0, int_out}, 8'h01);
        inta_n = 1'b0;
        tick();
        check("aeoi_isr_set", isr, 8'h80);
        irr = 8'h00;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check("aeoi_data_out", data_out, 8'h47);
        inta_n = 1'b1;
        tick();
        check("aeoi_isr_clear", isr, 8'h00);
        aeoi = 1'b0;

        // Reset in WAIT2 after a rotate moved the priority base
        irr = 8'h02;
        tick();
        inta_n = 1'b0;
        tick();
        irr = 8'h00;
        inta_n = 1'b1;
        tick();
        eoi(1'b1, 1'b1, 3'd1);
        check("mid_lowest_prio", {5'd0, dut.lowest_prio}, 8'h01);
        rst = 1'b1;
        #1;
        check("mid_rst_lowest_prio", {5'd0, dut.lowest_prio}, 8'h07);
        check("mid_rst_isr", isr, 8'h00);
        check("mid_rst_int_out", {7'd0, int_out}, 8'h00);
        check("mid_rst_data_oe", {7'd0, data_oe}, 8'h00);
        check("mid_rst_data_out", data_out, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        irr = 8'h04;
        tick();
        check("post_rst_int_out", {7'd0, int_out}, 8'h01);
        inta_cycle(clr_seen, isr_seen, dout_seen, doe_seen);
        check("post_rst_irr_clear", clr_seen, 8'h04);
        check("post_rst_isr", isr_seen, 8'h04);
        check("post_rst_data_out", dout_seen, 8'h42);
        check("post_rst_data_oe", {7'd0, doe_seen}, 8'h01);
        check("post_rst_data_oe_off", {7'd0, data_oe}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
